mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_ctrl_timeout_cnt.sv | 47 ++++
 rtl/mem_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the data-memory access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, data-path width, default timeout length and the
// latched RAM command struct, plus a word-alignment helper.
package mem_ctrl_pkg;

  // Width of the pipeline data/address path.
  localparam int REG_W = 32;

  // Default number of BUSY cycles tolerated before a timeout is declared.
  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Request as presented to the data RAM; captured once on entry to BUSY.
  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] addr;
    logic [REG_W-1:0] wdata;
  } ram_cmd_t;

  // The RAM is word addressed in bytes: the two low address bits are dropped.
  function automatic logic [REG_W-1:0] word_align(input logic [REG_W-1:0] a);
    return {a[REG_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_ctrl_timeout_cnt.sv
// mem_timeout_cnt: counts BUSY cycles without an acknowledge and flags expiry.
// Latency: expired_o is combinational from the registered count.
// Backpressure: none; counter simply saturates at its terminal value.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   clr_i         clear (asserted on the cycle the controller enters BUSY)
//   en_i          count enable (BUSY cycle with no acknowledge)
//   expired_o     count has reached its terminal value (TIMEOUT_CYCLES-th BUSY cycle)
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  // The first BUSY cycle sees a count of 0, so the N-th BUSY cycle sees N-1.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      // Saturate rather than wrap so a late ack cannot re-arm the timer.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: bridges the MEM pipeline stage to a req/ack data RAM.
// Latency: 1 IDLE + >=1 BUSY cycles stalled, result visible in the following DONE cycle.
// Backpressure: stallreq_o holds the pipeline while a request is outstanding.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   ce_i, we_i, addr_i, wdata_i      access request from the MEM stage
//   rdata_o                          load data back to the MEM stage (held until next read)
//   stallreq_o                       pipeline stall request
//   ram_req_o, ram_we_o,
//   ram_addr_o, ram_wdata_o          registered request to the data RAM
//   ram_ack_i, ram_rdata_i           one-cycle completion strobe and read data
//   err_o                            one-cycle timeout pulse (DONE cycle)
// Build option: define MEM_CTRL_TIMEOUT_EN to bound the BUSY wait to TIMEOUT_CYCLES;
// without it BUSY waits indefinitely and err_o is tied low.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stallreq_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_ack_i,
  input  logic [31:0] ram_rdata_i,
  output logic        err_o
);

  state_e           state_q;
  state_e           state_d;
  ram_cmd_t         cmd_q;
  ram_cmd_t         cmd_d;
  logic [REG_W-1:0] rdata_q;
  logic [REG_W-1:0] rdata_d;

  logic start;        // accepted request this cycle (IDLE and ce_i)
  logic busy;
  logic ack_hit;      // acknowledge that actually completes the access
  logic timeout_hit;  // BUSY abandoned for lack of acknowledge

  assign start   = (state_q == ST_IDLE) && ce_i;
  assign busy    = (state_q == ST_BUSY);
  // Acks arriving in IDLE or DONE are stray and must not disturb anything.
  assign ack_hit = busy && ram_ack_i;

`ifdef MEM_CTRL_TIMEOUT_EN
  logic cnt_expired;
  logic err_q;

  mem_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (start),
    .en_i     (busy && !ram_ack_i),
    .expired_o(cnt_expired)
  );

  // An ack on the final cycle wins over the timeout.
  assign timeout_hit = busy && !ram_ack_i && cnt_expired;

  // err_q is set only on the BUSY->DONE edge caused by a timeout, so it is
  // high for exactly the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
    end
  end

  assign err_o = err_q;
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
  assign err_o                 = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ce_i) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // ce_i is not looked at here: the latched request always runs to completion.
        if (ram_ack_i || timeout_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // One non-stalled cycle for the pipeline to advance past the access.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_req_o  = 1'b0;
    stallreq_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Stall in the request cycle itself, so the MEM stage holds its operands.
        stallreq_o = ce_i;
      end
      ST_BUSY: begin
        ram_req_o  = 1'b1;
        stallreq_o = 1'b1;
      end
      default: begin
        ram_req_o  = 1'b0;
        stallreq_o = 1'b0;
      end
    endcase
    // Async reset forces IDLE, but ce_i could still be high; keep the stall quiet.
    if (rst) begin
      stallreq_o = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: command capture and load-data register
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    if (start) begin
      cmd_d.we    = we_i;
      cmd_d.addr  = word_align(addr_i);
      cmd_d.wdata = wdata_i;
    end
    if (ack_hit && !cmd_q.we) begin
      rdata_d = ram_rdata_i;
    end else if (timeout_hit && !cmd_q.we) begin
      // A timed-out load returns zero rather than stale data.
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
    end
  end

  assign ram_we_o    = cmd_q.we;
  assign ram_addr_o  = cmd_q.addr;
  assign ram_wdata_o = cmd_q.wdata;
  assign rdata_o     = rdata_q;

endmodule
